div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 31 +++
 rtl/div_step.sv | 32 +++
 rtl/div_seq.sv | 137 +++++++++++++
 tb/tb_div_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   state_t   : controller state encoding (IDLE / CALC / DONE)
//   ST_DZ/ST_Z: bit positions inside status_o
//   cnt_width : step-counter width for a given operand width
// Provides fallback values for the WORD / W_RD macros so the
// slice also builds when no global definitions header is present.
`ifndef WORD
`define WORD 32
`endif
`ifndef W_RD
`define W_RD 5
`endif

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ST_DZ = 1;
  localparam int ST_Z  = 0;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(`WORD);

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
//   rem_i  : partial remainder
//   quo_i  : remaining dividend bits (MSB next) / quotient bits so far
//   dvsr_i : divisor
//   rem_o  : next partial remainder
//   quo_o  : quotient register shifted left with the new quotient bit
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = `WORD
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] low;
  logic             ge;

  // The trial value is {rem_i, next dividend bit}, WIDTH+1 bits wide.
  // Its top bit is rem_i's MSB; when set, the trial is certainly >= the
  // divisor and the WIDTH-bit wrap-around subtraction is still exact.
  always_comb begin
    low   = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
    ge    = rem_i[WIDTH-1] || (low >= dvsr_i);
    rem_o = ge ? (low - dvsr_i) : low;
    quo_o = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle unsigned divider for the ID/EX pipeline.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a valid div instruction, stall_o low
//   CALC  | one restoring step per cycle, counter counts WIDTH..1
//   DONE  | result presented, wb_o strobe (unless flushed), back to IDLE
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   v_i, div_i      : instruction valid and div decode; accepted in IDLE
//   opc_i           : 0 = quotient, 1 = remainder
//   src_i, dest_i   : divisor, dividend (unsigned)
//   wb_i, rd_num_i  : write-back enable and destination register
//   flush_i         : aborts the operation in flight, blocks accept in IDLE
//   stall_o         : high whenever the divider is not IDLE
//   wb_o            : one-cycle write strobe in DONE
//   rd_num_o        : destination register (0 outside DONE)
//   rd_data_o       : quotient or remainder (0 outside DONE)
//   status_o        : {DZ, Z} (0 outside DONE)
//
// Optional feature: define DIV_EARLY_OUT_EN to finish a division by zero
// or a division with dividend < divisor directly from IDLE to DONE.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = `WORD,
  parameter int W_RD  = `W_RD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  input  logic             div_i,
  input  logic             opc_i,
  input  logic [WIDTH-1:0] src_i,
  input  logic [WIDTH-1:0] dest_i,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  rd_num_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             wb_o,
  output logic [W_RD-1:0]  rd_num_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [1:0]       status_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             opc_q, wb_q;
  logic [W_RD-1:0]  rd_q;
  logic             accept, early;
  logic [WIDTH-1:0] result;

  assign accept = (state == IDLE) && v_i && div_i && !flush_i;

`ifdef DIV_EARLY_OUT_EN
  assign early = (src_i == '0) || (dest_i < src_i);
`else
  assign early = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_step),
    .quo_o  (quo_step)
  );

  // After WIDTH steps rem_q/quo_q hold remainder/quotient; a zero divisor
  // naturally yields all-ones quotient and remainder == dividend.
  assign result  = opc_q ? rem_q : quo_q;
  assign stall_o = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wb_o      = 1'b0;
    rd_num_o  = '0;
    rd_data_o = '0;
    status_o  = '0;
    case (state)
      IDLE: if (accept) state_nxt = early ? DONE : CALC;
      CALC: begin
        if (flush_i)             state_nxt = IDLE;
        else if (cnt == CW'(1))  state_nxt = DONE;
      end
      DONE: begin
        state_nxt       = IDLE;
        wb_o            = wb_q && !flush_i;
        rd_num_o        = rd_q;
        rd_data_o       = result;
        status_o[ST_DZ] = (dvsr_q == '0);
        status_o[ST_Z]  = (result == '0);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      opc_q  <= 1'b0;
      wb_q   <= 1'b0;
      rd_q   <= '0;
    end else if (accept) begin
      cnt    <= CW'(WIDTH);
      dvsr_q <= src_i;
      opc_q  <= opc_i;
      wb_q   <= wb_i;
      rd_q   <= rd_num_i;
      if (early) begin
        rem_q <= dest_i;
        quo_q <= (src_i == '0) ? '1 : '0;
      end else begin
        rem_q <= '0;
        quo_q <= dest_i;
      end
    end else if ((state == CALC) && !flush_i) begin
      cnt   <= cnt - CW'(1);
      rem_q <= rem_step;
      quo_q <= quo_step;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized
// divisions compared against plain integer arithmetic.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_i = 1'b0, div_i = 1'b0, opc_i = 1'b0, wb_i = 1'b0, flush_i = 1'b0;
  logic [31:0] src_i = '0, dest_i = '0;
  logic [4:0]  rd_num_i = '0;
  logic        stall_o, wb_o;
  logic [4:0]  rd_num_o;
  logic [31:0] rd_data_o;
  logic [1:0]  status_o;

  int total = 0;
  int bad   = 0;

  div_seq dut (
    .clk(clk), .rst(rst), .v_i(v_i), .div_i(div_i), .opc_i(opc_i),
    .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i), .rd_num_i(rd_num_i),
    .flush_i(flush_i), .stall_o(stall_o), .wb_o(wb_o), .rd_num_o(rd_num_o),
    .rd_data_o(rd_data_o), .status_o(status_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                         input logic op);
    logic [31:0] q, r;
    q = (b == 0) ? 32'hFFFF_FFFF : a / b;
    r = (b == 0) ? a : a % b;
    return op ? r : q;
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || a < b) return 1;
`endif
    return 33;
  endfunction

  task automatic present(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [4:0] rd);
    v_i = 1'b1; div_i = 1'b1; wb_i = 1'b1;
    dest_i = a; src_i = b; opc_i = op; rd_num_i = rd;
  endtask

  task automatic release_in();
    v_i = 1'b0; div_i = 1'b0; wb_i = 1'b0;
  endtask

  // Starts just after an edge with the DUT idle; returns one cycle after wb_o.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [4:0] rd);
    logic [31:0] exp;
    int n, stalls;
    exp = ref_res(a, b, op);
    present(a, b, op, rd);
    chk({tag, ".stall_acc"}, stall_o, 0);
    step();
    release_in();
    n = 1; stalls = 0;
    while (!wb_o && n < 60) begin
      if (stall_o) stalls++;
      step();
      n++;
    end
    if (stall_o) stalls++;
    chk({tag, ".lat"}, n, ref_lat(a, b));
    chk({tag, ".stalls"}, stalls, ref_lat(a, b));
    chk({tag, ".rd"}, rd_num_o, rd);
    chk({tag, ".data"}, rd_data_o, exp);
    chk({tag, ".status"}, status_o, {b == 0, exp == 0});
    step();
    chk({tag, ".wb_one"}, wb_o, 0);
    chk({tag, ".idle"}, stall_o, 0);
  endtask

  task automatic count_wb(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (wb_o) seen++;
      step();
    end
  endtask

  initial begin
    int seen, n;
    int wb_at[$];
    logic [31:0] wb_dat[$];
    logic [31:0] a, b;

    #2;
    chk("rst.stall", stall_o, 0);
    chk("rst.wb", wb_o, 0);
    chk("rst.data", rd_data_o, 0);
    chk("rst.status", status_o, 0);
    step(); step();
    rst = 1'b1;
    step();

    run_div("q100_7", 100, 7, 1'b0, 5'd3);
    run_div("r100_7", 100, 7, 1'b1, 5'd4);
    run_div("r7_7", 7, 7, 1'b1, 5'd5);
    run_div("q5_0", 5, 0, 1'b0, 5'd6);
    run_div("r5_0", 5, 0, 1'b1, 5'd7);
    run_div("q3_10", 3, 10, 1'b0, 5'd8);
    run_div("qmax_1", 32'hFFFF_FFFF, 1, 1'b0, 5'd31);

    // Not accepted: div_i low, or flush in IDLE.
    v_i = 1'b1; div_i = 1'b0; step();
    chk("nodiv.stall", stall_o, 0);
    present(10, 3, 1'b0, 5'd1); flush_i = 1'b1; step();
    chk("flush_idle.stall", stall_o, 0);
    flush_i = 1'b0; release_in();
    step();

    // Flush during CALC: flush held in cycle T+10.
    present(1000, 3, 1'b0, 5'd2); step(); release_in();
    repeat (9) step();
    flush_i = 1'b1;
    #1 chk("flush.wb_in", wb_o, 0);
    chk("flush.busy", stall_o, 1);
    step(); flush_i = 1'b0;
    chk("flush.idle", stall_o, 0);
    count_wb(40, seen);
    chk("flush.no_wb", seen, 0);

    // Asynchronous reset in cycle T+5.
    present(1000, 3, 1'b0, 5'd2); step(); release_in();
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    chk("arst.stall", stall_o, 0);
    chk("arst.wb", wb_o, 0);
    chk("arst.rd", rd_num_o, 0);
    chk("arst.data", rd_data_o, 0);
    chk("arst.status", status_o, 0);
    step(); rst = 1'b1; step();
    count_wb(40, seen);
    chk("arst.no_wb", seen, 0);

    // Back-to-back: second instruction held under stall.
    present(100, 7, 1'b0, 5'd9); step();
    present(200, 9, 1'b1, 5'd10);
    n = 1;
    while (n <= 80) begin
      if (wb_o) begin wb_at.push_back(n); wb_dat.push_back(rd_data_o); end
      if (!stall_o) begin
        step(); release_in();
      end else step();
      n++;
    end
    chk("b2b.count", wb_at.size(), 2);
    if (wb_at.size() == 2) begin
      chk("b2b.t1", wb_at[0], 33);
      chk("b2b.t2", wb_at[1], 67);
      chk("b2b.d1", wb_dat[0], 14);
      chk("b2b.d2", wb_dat[1], 2);
    end

    // Randomized divisions against integer arithmetic.
    for (int i = 0; i < 24; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
